// File: rtl/alu_arb_ysyx_if.sv
// Request/ALU/response bundle for the shared-ALU arbiter.
// The slave modport is the arbiter; the master modport is the surrounding issue/ALU logic.
interface alu_arb_ysyx_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;

    logic [3:0]       req0_ctr;
    logic             req0_asrc;
    logic [1:0]       req0_bsrc;
    logic [XLEN-1:0]  req0_pc;
    logic [XLEN-1:0]  req0_rs1;
    logic [XLEN-1:0]  req0_rs2;
    logic [XLEN-1:0]  req0_imm;
    logic [TAG_W-1:0] req0_tag;

    logic [3:0]       req1_ctr;
    logic             req1_asrc;
    logic [1:0]       req1_bsrc;
    logic [XLEN-1:0]  req1_pc;
    logic [XLEN-1:0]  req1_rs1;
    logic [XLEN-1:0]  req1_rs2;
    logic [XLEN-1:0]  req1_imm;
    logic [TAG_W-1:0] req1_tag;

    logic [XLEN-1:0]  alu_pc;
    logic [XLEN-1:0]  alu_rs1;
    logic [XLEN-1:0]  alu_rs2;
    logic [XLEN-1:0]  alu_imm;
    logic [3:0]       alu_ctr;
    logic             alu_asrc;
    logic [1:0]       alu_bsrc;
    logic [XLEN-1:0]  alu_result;
    logic             alu_less;
    logic             alu_zero;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [TAG_W-1:0] rsp_tag;
    logic [XLEN-1:0]  rsp_result;
    logic             rsp_less;
    logic             rsp_zero;
    logic             busy;

    modport slave (
        input  req_valid,
        input  req0_ctr, req0_asrc, req0_bsrc, req0_pc, req0_rs1, req0_rs2, req0_imm, req0_tag,
        input  req1_ctr, req1_asrc, req1_bsrc, req1_pc, req1_rs1, req1_rs2, req1_imm, req1_tag,
        input  alu_result, alu_less, alu_zero,
        input  rsp_ready,
        output req_ready,
        output alu_pc, alu_rs1, alu_rs2, alu_imm, alu_ctr, alu_asrc, alu_bsrc,
        output rsp_valid, rsp_id, rsp_tag, rsp_result, rsp_less, rsp_zero,
        output busy
    );

    modport master (
        output req_valid,
        output req0_ctr, req0_asrc, req0_bsrc, req0_pc, req0_rs1, req0_rs2, req0_imm, req0_tag,
        output req1_ctr, req1_asrc, req1_bsrc, req1_pc, req1_rs1, req1_rs2, req1_imm, req1_tag,
        output alu_result, alu_less, alu_zero,
        output rsp_ready,
        input  req_ready,
        input  alu_pc, alu_rs1, alu_rs2, alu_imm, alu_ctr, alu_asrc, alu_bsrc,
        input  rsp_valid, rsp_id, rsp_tag, rsp_result, rsp_less, rsp_zero,
        input  busy
    );
endinterface

// File: rtl/alu_arb_ysyx.sv
// Round-robin arbiter sharing one ALU between the EXU (req 0) and LSU address generation (req 1).
// state | meaning
// IDLE  | grant a requester, latch its operation into the alu_* registers
// EXEC  | alu_* registers drive the ALU; its outputs are captured at the end of this cycle
// RESP  | rsp_valid high, fields held until rsp_ready
module alu_arb_ysyx #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    alu_arb_ysyx_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state;
    logic             last_grant;
    logic             op_id;
    logic [TAG_W-1:0] op_tag;
    logic             grant_vld;
    logic             grant_idx;

    // With both requesting, the one not served last wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = 1'b0;
        if (state == IDLE) begin
            if (bus.req_valid == 2'b11) begin
                grant_vld = 1'b1;
                grant_idx = ~last_grant;
            end else if (bus.req_valid[0]) begin
                grant_vld = 1'b1;
                grant_idx = 1'b0;
            end else if (bus.req_valid[1]) begin
                grant_vld = 1'b1;
                grant_idx = 1'b1;
            end
        end
    end

    assign bus.req_ready = {grant_vld & grant_idx, grant_vld & ~grant_idx};
    assign bus.busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            last_grant     <= 1'b1;
            op_id          <= 1'b0;
            op_tag         <= '0;
            bus.alu_pc     <= '0;
            bus.alu_rs1    <= '0;
            bus.alu_rs2    <= '0;
            bus.alu_imm    <= '0;
            bus.alu_ctr    <= 4'b0000;
            bus.alu_asrc   <= 1'b0;
            bus.alu_bsrc   <= 2'b00;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_id     <= 1'b0;
            bus.rsp_tag    <= '0;
            bus.rsp_result <= '0;
            bus.rsp_less   <= 1'b0;
            bus.rsp_zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        state      <= EXEC;
                        last_grant <= grant_idx;
                        op_id      <= grant_idx;
                        if (grant_idx) begin
                            bus.alu_ctr  <= bus.req1_ctr;
                            bus.alu_asrc <= bus.req1_asrc;
                            bus.alu_bsrc <= bus.req1_bsrc;
                            bus.alu_pc   <= bus.req1_pc;
                            bus.alu_rs1  <= bus.req1_rs1;
                            bus.alu_rs2  <= bus.req1_rs2;
                            bus.alu_imm  <= bus.req1_imm;
                            op_tag       <= bus.req1_tag;
                        end else begin
                            bus.alu_ctr  <= bus.req0_ctr;
                            bus.alu_asrc <= bus.req0_asrc;
                            bus.alu_bsrc <= bus.req0_bsrc;
                            bus.alu_pc   <= bus.req0_pc;
                            bus.alu_rs1  <= bus.req0_rs1;
                            bus.alu_rs2  <= bus.req0_rs2;
                            bus.alu_imm  <= bus.req0_imm;
                            op_tag       <= bus.req0_tag;
                        end
                    end
                end
                EXEC: begin
                    state          <= RESP;
                    bus.rsp_valid  <= 1'b1;
                    bus.rsp_id     <= op_id;
                    bus.rsp_tag    <= op_tag;
                    bus.rsp_result <= bus.alu_result;
                    bus.rsp_less   <= bus.alu_less;
                    bus.rsp_zero   <= bus.alu_zero;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state         <= IDLE;
                        bus.rsp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arb_ysyx.sv
// Scoreboard bench for alu_arb_ysyx with a behavioural ALU attached to the alu_* outputs.
module tb_alu_arb_ysyx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_arb_ysyx_if #(.XLEN(32), .TAG_W(4)) bus ();
    alu_arb_ysyx #(.XLEN(32), .TAG_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic        id;
        logic [3:0]  tag;
        logic [31:0] result;
        logic        less;
        logic        zero;
    } exp_t;

    exp_t        exp_q[$];
    int          grant_log[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          hs_cyc = 0;
    logic        prev_rsp_valid = 1'b0;
    logic [31:0] last_result[2];
    logic        last_less[2];
    logic        last_zero[2];

    function automatic logic [33:0] ref_alu(input logic [3:0] ctr, input logic asrc,
                                            input logic [1:0] bsrc, input logic [31:0] pc,
                                            input logic [31:0] rs1, input logic [31:0] rs2,
                                            input logic [31:0] imm);
        logic [31:0] a, b, r;
        logic        less;
        a = asrc ? pc : rs1;
        case (bsrc)
            2'b00:   b = rs2;
            2'b01:   b = imm;
            default: b = 32'd4;
        endcase
        less = ctr[3] ? (a < b) : ($signed(a) < $signed(b));
        case (ctr)
            4'b1000: r = a - b;
            4'b0010: r = {31'b0, $signed(a) < $signed(b)};
            4'b1010: r = {31'b0, a < b};
            4'b0100: r = a ^ b;
            4'b0110: r = a | b;
            4'b0111: r = a & b;
            4'b0011: r = b;
            4'b0001: r = a << b[4:0];
            4'b0101: r = a >> b[4:0];
            4'b1101: r = $signed(a) >>> b[4:0];
            default: r = a + b;
        endcase
        return {r, less, (r == 32'd0)};
    endfunction

    always_comb begin
        logic [33:0] o;
        o = ref_alu(bus.alu_ctr, bus.alu_asrc, bus.alu_bsrc, bus.alu_pc,
                    bus.alu_rs1, bus.alu_rs2, bus.alu_imm);
        bus.alu_result = o[33:2];
        bus.alu_less   = o[1];
        bus.alu_zero   = o[0];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Monitor: push on request handshake, pop and compare on response handshake.
    always @(negedge clk) begin
        exp_t        e;
        logic [33:0] o;
        cyc++;
        if (!rst) begin
            if (bus.req_valid[0] && bus.req_ready[0]) begin
                o = ref_alu(bus.req0_ctr, bus.req0_asrc, bus.req0_bsrc, bus.req0_pc,
                            bus.req0_rs1, bus.req0_rs2, bus.req0_imm);
                e = '{id: 1'b0, tag: bus.req0_tag, result: o[33:2], less: o[1], zero: o[0]};
                exp_q.push_back(e);
                grant_log.push_back(0);
                hs_cyc = cyc;
            end
            if (bus.req_valid[1] && bus.req_ready[1]) begin
                o = ref_alu(bus.req1_ctr, bus.req1_asrc, bus.req1_bsrc, bus.req1_pc,
                            bus.req1_rs1, bus.req1_rs2, bus.req1_imm);
                e = '{id: 1'b1, tag: bus.req1_tag, result: o[33:2], less: o[1], zero: o[0]};
                exp_q.push_back(e);
                grant_log.push_back(1);
                hs_cyc = cyc;
            end
            if (bus.rsp_valid && !prev_rsp_valid)
                chk("rsp_latency", cyc - hs_cyc, 2);
            if (bus.rsp_valid && bus.rsp_ready) begin
                chk("rsp_q_empty", exp_q.size() == 0, 0);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("rsp_id", bus.rsp_id, e.id);
                    chk("rsp_tag", bus.rsp_tag, e.tag);
                    chk("rsp_result", bus.rsp_result, e.result);
                    chk("rsp_less", bus.rsp_less, e.less);
                    chk("rsp_zero", bus.rsp_zero, e.zero);
                    last_result[bus.rsp_id] = bus.rsp_result;
                    last_less[bus.rsp_id]   = bus.rsp_less;
                    last_zero[bus.rsp_id]   = bus.rsp_zero;
                end
            end
        end
        prev_rsp_valid = bus.rsp_valid;
    end

    task automatic drive(input int idx, input logic [3:0] ctr, input logic asrc,
                         input logic [1:0] bsrc, input logic [31:0] pc, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] imm, input logic [3:0] tag);
        if (idx == 0) begin
            bus.req0_ctr = ctr; bus.req0_asrc = asrc; bus.req0_bsrc = bsrc;
            bus.req0_pc = pc; bus.req0_rs1 = rs1; bus.req0_rs2 = rs2;
            bus.req0_imm = imm; bus.req0_tag = tag;
            bus.req_valid[0] = 1'b1;
        end else begin
            bus.req1_ctr = ctr; bus.req1_asrc = asrc; bus.req1_bsrc = bsrc;
            bus.req1_pc = pc; bus.req1_rs1 = rs1; bus.req1_rs2 = rs2;
            bus.req1_imm = imm; bus.req1_tag = tag;
            bus.req_valid[1] = 1'b1;
        end
    endtask

    task automatic wait_hs(input int idx);
        int n = 0;
        while (n < 50) begin
            @(negedge clk);
            if (bus.req_ready[idx]) break;
            n++;
        end
        chk("hs_timeout", n < 50, 1);
        @(posedge clk);
        #1 bus.req_valid[idx] = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (n < 50) begin
            @(negedge clk);
            if (!bus.busy) break;
            n++;
        end
        chk("idle_timeout", n < 50, 1);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b1;
        drive(0, 4'b0, 1'b0, 2'b0, 0, 0, 0, 0, 0);
        drive(1, 4'b0, 1'b0, 2'b0, 0, 0, 0, 0, 0);
        bus.req_valid = 2'b00;
        apply_reset();

        // Reset values
        @(negedge clk);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_result", bus.rsp_result, 0);
        chk("rst_rsp_tag", bus.rsp_tag, 0);
        chk("rst_alu_ctr", bus.alu_ctr, 0);
        chk("rst_alu_rs1", bus.alu_rs1, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_req_ready", bus.req_ready, 0);

        // Single add from req0
        @(posedge clk); #1;
        drive(0, 4'b0000, 1'b0, 2'b00, 0, 32'd5, 32'd7, 0, 4'd3);
        #1 chk("add_req_ready", bus.req_ready, 2'b01);
        wait_hs(0);
        wait_idle();
        chk("add_result", last_result[0], 32'd12);
        chk("add_zero", last_zero[0], 0);

        // Both valid continuously from reset: round robin
        apply_reset();
        grant_log.delete();
        drive(0, 4'b0000, 1'b0, 2'b00, 0, 32'd10, 32'd20, 0, 4'd1);
        drive(1, 4'b0000, 1'b1, 2'b10, 32'h8000_0000, 0, 0, 0, 4'd2);
        repeat (13) @(negedge clk);
        @(posedge clk); #1 bus.req_valid = 2'b00;
        wait_idle();
        chk("rr_count", grant_log.size() >= 4, 1);
        if (grant_log.size() >= 4) begin
            chk("rr_g0", grant_log[0], 0);
            chk("rr_g1", grant_log[1], 1);
            chk("rr_g2", grant_log[2], 0);
            chk("rr_g3", grant_log[3], 1);
        end
        chk("rr_pc4", last_result[1], 32'h8000_0004);

        // Signed vs unsigned compare
        @(posedge clk); #1;
        drive(0, 4'b0010, 1'b0, 2'b00, 0, 32'hFFFF_FFFF, 32'd1, 0, 4'd4);
        wait_hs(0);
        wait_idle();
        chk("slt_result", last_result[0], 1);
        chk("slt_less", last_less[0], 1);
        @(posedge clk); #1;
        drive(0, 4'b1010, 1'b0, 2'b00, 0, 32'hFFFF_FFFF, 32'd1, 0, 4'd5);
        wait_hs(0);
        wait_idle();
        chk("sltu_result", last_result[0], 0);
        chk("sltu_less", last_less[0], 0);

        // Sub with equal operands, immediate source
        @(posedge clk); #1;
        drive(1, 4'b1000, 1'b0, 2'b01, 0, 32'h1234, 0, 32'h1234, 4'd6);
        wait_hs(1);
        wait_idle();
        chk("sub_result", last_result[1], 0);
        chk("sub_zero", last_zero[1], 1);

        // Backpressure
        begin
            int n = 0;
            int g_before;
            @(posedge clk); #1;
            bus.rsp_ready = 1'b0;
            drive(0, 4'b0100, 1'b0, 2'b00, 0, 32'hA5A5, 32'h0F0F, 0, 4'd9);
            wait_hs(0);
            drive(1, 4'b0000, 1'b0, 2'b00, 0, 32'd1, 32'd2, 0, 4'd5);
            while (n < 10 && !bus.rsp_valid) begin
                @(negedge clk);
                n++;
            end
            chk("bp_valid_timeout", n < 10, 1);
            g_before = grant_log.size();
            for (int i = 0; i < 4; i++) begin
                if (i > 0) @(negedge clk);
                chk("bp_rsp_valid", bus.rsp_valid, 1);
                chk("bp_rsp_result", bus.rsp_result, 32'hAAAA);
                chk("bp_rsp_tag", bus.rsp_tag, 4'd9);
                chk("bp_rsp_id", bus.rsp_id, 0);
                chk("bp_req_ready", bus.req_ready, 2'b00);
                chk("bp_busy", bus.busy, 1);
            end
            chk("bp_no_grant", grant_log.size(), g_before);
            @(posedge clk); #1 bus.rsp_ready = 1'b1;
            wait_hs(1);
            wait_idle();
            chk("bp_next_grant", grant_log[grant_log.size()-1], 1);
            chk("bp_next_result", last_result[1], 32'd3);
        end

        // Reset during EXEC drops the op; req0 then wins again
        @(posedge clk); #1;
        drive(1, 4'b0110, 1'b0, 2'b00, 0, 32'hF0, 32'h0F, 0, 4'd7);
        wait_hs(1);
        #1 rst = 1'b1;
        #1;
        chk("rst_exec_rsp_valid", bus.rsp_valid, 0);
        chk("rst_exec_busy", bus.busy, 0);
        exp_q.delete();
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_exec_no_rsp", bus.rsp_valid, 0);
        end
        grant_log.delete();
        @(posedge clk); #1;
        drive(0, 4'b0111, 1'b0, 2'b00, 0, 32'hFF00, 32'h0FF0, 0, 4'd8);
        drive(1, 4'b0001, 1'b0, 2'b01, 0, 32'd1, 0, 32'd4, 4'd2);
        wait_hs(0);
        wait_hs(1);
        wait_idle();
        chk("post_rst_first", grant_log.size() >= 1 ? grant_log[0] : -1, 0);
        chk("post_rst_and", last_result[0], 32'h0F00);
        chk("post_rst_sll", last_result[1], 32'h10);
        chk("q_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
